mac_triple_driver: RTL and testbench
====================================

MAC_TRIPLE_DRIVER -- requirements
Module: mac_triple_driver

Interface
REQ-001 Parameter: WIDTH, default 32, data width of operands, data_in and data_out.
REQ-002 Parameter: TIMEOUT, default 4, cycles to wait for valido after the third operand before flagging an error.
REQ-003 Parameter: GAP, default 1, minimum cycles (at least 1) that validi is held low between consecutive triples.
REQ-004 Port: clk  in  1  single clock; all logic on posedge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  in  1  host offers an operand triple.
REQ-007 Port: req_ready  out  1  driver accepts the triple this cycle.
REQ-008 Port: req_a, req_b, req_c  in  WIDTH each  operands; the DUT computes a*b+c.
REQ-009 Port: validi  out  1  operand-stream valid toward the MAC DUT.
REQ-010 Port: data_in  out  WIDTH  operand stream toward the DUT.
REQ-011 Port: valido  in  1  DUT result valid.
REQ-012 Port: data_out  in  WIDTH  DUT result.
REQ-013 Port: rsp_valid  out  1  result available to the host.
REQ-014 Port: rsp_ready  in  1  host consumes the result.
REQ-015 Port: rsp_data  out  WIDTH  captured data_out, or 0 on timeout.
REQ-016 Port: rsp_mismatch  out  1  captured data_out differs from (a*b+c) mod 2^WIDTH.
REQ-017 Port: rsp_timeout  out  1  valido not seen within TIMEOUT cycles.

Function
REQ-018 The FSM SHALL have the states IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP and GAP.
REQ-019 req_ready SHALL be 1 only in IDLE; req_valid && req_ready SHALL latch a, b and c and move to SEND_A.
REQ-020 SEND_A, SEND_B and SEND_C SHALL each last exactly 1 cycle, with validi=1 and data_in equal to a, b and c respectively; this gives exactly 3 consecutive validi cycles.
REQ-021 validi SHALL be 0 and data_in SHALL be 0 in every other state; validi SHALL never be high for 4 or more consecutive cycles.
REQ-022 Expected value: exp = (a*b + c) truncated to WIDTH bits, with the product computed at full 2*WIDTH width before truncation; exp SHALL be registered by the end of SEND_C.
REQ-023 WAIT SHALL start the cycle after SEND_C; the nominal DUT latency is valido in the first WAIT cycle.
REQ-024 In WAIT, valido=1 SHALL capture data_out into rsp_data, set rsp_mismatch=(data_out!=exp) and rsp_timeout=0, and move to RESP.
REQ-025 In WAIT, a counter SHALL count WAIT cycles; if TIMEOUT cycles pass without valido, the driver SHALL go to RESP with rsp_timeout=1, rsp_mismatch=0 and rsp_data=0.
REQ-026 valido while in IDLE, SEND_* or GAP SHALL be ignored and SHALL NOT alter any rsp_* output.
REQ-027 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held stable until rsp_ready=1; that cycle moves to GAP.
REQ-028 GAP SHALL last GAP cycles, then return to IDLE; the earliest next SEND_A is GAP+1 cycles after RESP exits.
REQ-029 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-030 On rst=1 the block SHALL, asynchronously: set state to IDLE; set validi, data_in, rsp_valid, rsp_data, rsp_mismatch and rsp_timeout to 0; set req_ready to 1 (after rst deasserts) and clear the counters.
REQ-031 rst asserted during SEND_*, WAIT or RESP SHALL abandon the triple with no response issued; a later valido SHALL NOT produce a response.

Structure
REQ-032 Package mac_drv_pkg SHALL hold the state enum typedef, the default WIDTH/TIMEOUT/GAP localparams and a function exp_mac(a,b,c) returning the truncated result.
REQ-033 One sub-module, mac_timeout_cnt, SHALL contain the WAIT/GAP down-counter with load, enable and zero outputs; all other logic SHALL be in mac_triple_driver.

Verification
REQ-034 Triple a=3, b=4, c=5, DUT returns valido one cycle after c with data_out=17: validi high for exactly 3 cycles with data_in 3,4,5, then rsp_data=17, mismatch=0, timeout=0.
REQ-035 a=0xFFFF_FFFF, b=2, c=3, DUT returns 1: rsp_data=1, mismatch=0 (wrap-around).
REQ-036 DUT returns 16 for 3,4,5: rsp_mismatch=1 and rsp_data=16.
REQ-037 DUT never asserts valido: rsp_timeout=1 and rsp_data=0 after exactly 4 WAIT cycles; a stray valido in the GAP state is ignored.
REQ-038 Host holds rsp_ready=0 for 5 cycles while req_valid is held 1: rsp_* stay stable, req_ready stays 0, and the next triple starts GAP+1 cycles after rsp_ready=1; validi is 0 for at least GAP cycles between the triples.
REQ-039 rst pulsed during SEND_B: validi drops immediately, no rsp_valid is issued, and a triple 7,8,9 issued after reset returns 65.

Source files
------------

// File: rtl/mac_drv_pkg.sv
// Shared definitions for the MAC triple driver.
//   state_t      : driver FSM states
//   DEF_*        : default WIDTH / TIMEOUT / GAP values
//   exp_mac()    : reference a*b+c, returned at MAC_MAX_W bits. The caller
//                  truncates it to its own WIDTH (WIDTH <= MAC_MAX_W).
package mac_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_SEND_C,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 4;
  localparam int DEF_GAP     = 1;
  localparam int MAC_MAX_W   = 64;

  // The operands are zero-extended to MAC_MAX_W before they reach this
  // function. Because of that, the low WIDTH bits of the product equal the
  // low WIDTH bits of the full 2*WIDTH product.
  function automatic logic [MAC_MAX_W-1:0] exp_mac(input logic [MAC_MAX_W-1:0] a,
                                                   input logic [MAC_MAX_W-1:0] b,
                                                   input logic [MAC_MAX_W-1:0] c);
    return a * b + c;
  endfunction

endpackage

// File: rtl/mac_timeout_cnt.sv
// Down-counter shared by the WAIT timeout and the inter-triple GAP.
//   clk, rst : clock and asynchronous active-high reset
//   load     : load load_val (takes priority over en)
//   load_val : start value (cycles - 1)
//   en       : decrement; the counter saturates at zero
//   zero     : count is zero
module mac_timeout_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mac_triple_driver.sv
// Drives one a,b,c operand triple into a MAC DUT and checks its a*b+c result.
//   clk, rst                  : clock and asynchronous active-high reset
//   req_valid/req_ready       : host offers a triple (req_a, req_b, req_c)
//   validi/data_in            : three back-to-back operand beats to the DUT
//   valido/data_out           : DUT result; it is only looked at in WAIT
//   rsp_valid/rsp_ready       : result to host with rsp_data, rsp_mismatch,
//                               rsp_timeout
// Handshake rule, used on both host ports: a transfer happens on a rising
// clock edge where valid and ready are both 1. Once valid is raised, it and
// its data stay stable until that transfer happens.
module mac_triple_driver
  import mac_drv_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  output logic             validi,
  output logic [WIDTH-1:0] data_in,
  input  logic             valido,
  input  logic [WIDTH-1:0] data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_mismatch,
  output logic             rsp_timeout
);

  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // The counter ends on zero, so loading N-1 gives exactly N cycles.
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, op_c;
  logic [WIDTH-1:0] exp_val;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          cnt_zero;

  // Load TIMEOUT on entry to WAIT and GAP on entry to GAP. Count down
  // while in either state.
  always_comb begin
    cnt_load     = (state == ST_SEND_C) || ((state == ST_RESP) && rsp_ready);
    cnt_load_val = (state == ST_SEND_C) ? TO_LOAD : GAP_LOAD;
    cnt_en       = (state == ST_WAIT) || (state == ST_GAP);
  end

  mac_timeout_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // The outputs are set on the edge that enters each state, so validi and
  // data_in line up exactly with SEND_A/B/C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      validi       <= 1'b0;
      data_in      <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_c         <= '0;
      exp_val      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_a      <= req_a;
            op_b      <= req_b;
            op_c      <= req_c;
            req_ready <= 1'b0;
            validi    <= 1'b1;
            data_in   <= req_a;
            state     <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          data_in <= op_b;
          state   <= ST_SEND_B;
        end
        ST_SEND_B: begin
          data_in <= op_c;
          exp_val <= WIDTH'(exp_mac(MAC_MAX_W'(op_a), MAC_MAX_W'(op_b), MAC_MAX_W'(op_c)));
          state   <= ST_SEND_C;
        end
        ST_SEND_C: begin
          validi  <= 1'b0;
          data_in <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result in the last allowed cycle still wins over the timeout.
          if (valido) begin
            rsp_data     <= data_out;
            rsp_mismatch <= (data_out != exp_val);
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end else if (cnt_zero) begin
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          validi    <= 1'b0;
          data_in   <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_triple_driver.sv
module tb_mac_triple_driver;

  localparam int W  = 32;
  localparam int TO = 4;
  localparam int GP = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic         validi;
  logic [W-1:0] data_in;
  logic         valido = 1'b0;
  logic [W-1:0] data_out = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_mismatch;
  logic         rsp_timeout;

  mac_triple_driver #(.WIDTH(W), .TIMEOUT(TO), .GAP(GP)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .validi       (validi),
    .data_in      (data_in),
    .valido       (valido),
    .data_out     (data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_mismatch (rsp_mismatch),
    .rsp_timeout  (rsp_timeout)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // validi stream monitor: longest high run and shortest low run between runs
  int   run_len = 0, low_len = 0, max_run = 0, min_low = 1000;
  logic seen_run = 1'b0;
  always @(negedge clk) begin
    if (validi) begin
      if (run_len == 0 && seen_run && low_len < min_low) min_low = low_len;
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
      low_len = 0;
    end else begin
      if (run_len > 0) seen_run = 1'b1;
      run_len = 0;
      low_len = low_len + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_mac(input logic [W-1:0] a, b, c);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, c};
    return full[W-1:0];
  endfunction

  // ---------------- driver task ----------------
  // Plays both the host and the MAC DUT for one triple. lat is the WAIT
  // cycle (0 = first) in which the fake DUT raises valido; a negative lat
  // means it never does. use_val sends val back instead of the correct
  // result. The task returns at the negedge of the first GAP cycle.
  task automatic run_triple(input logic [W-1:0] a, b, c, input int lat,
                            input logic use_val, input logic [W-1:0] val,
                            input int hold, input logic keep_req,
                            output logic [W-1:0] op0, op1, op2, output int vrun,
                            output logic din_zero, output int waitc,
                            output logic [W-1:0] r_data, output logic r_mis, r_to,
                            output int unstable, output int t_send, t_hs);
    logic [W-1:0] good;
    int n;
    good = model_mac(a, b, c);
    req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    if (!keep_req) req_valid = 1'b0;
    t_send = cyc;
    vrun = 0; op0 = '0; op1 = '0; op2 = '0;
    while (validi && vrun < 6) begin
      case (vrun)
        0: op0 = data_in;
        1: op1 = data_in;
        2: op2 = data_in;
        default: ;
      endcase
      vrun++;
      @(negedge clk);
    end
    din_zero = (data_in == '0);
    waitc = 0;
    while (!rsp_valid && waitc < 20) begin
      if (waitc == lat) begin
        valido = 1'b1;
        data_out = use_val ? val : good;
      end else begin
        valido = 1'b0;
        data_out = $urandom;
      end
      @(negedge clk);
      waitc++;
    end
    valido = 1'b0;
    r_data = rsp_data; r_mis = rsp_mismatch; r_to = rsp_timeout;
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== r_data || rsp_mismatch !== r_mis ||
          rsp_timeout !== r_to || req_ready !== 1'b0) unstable++;
    end
    rsp_ready = 1'b1;
    t_hs = cyc;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++; if (validi !== 1'b0 || data_in !== '0) begin tests_failed++; $display("FAIL reset_validi: got %b/%0h want 0/0", validi, data_in); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_mismatch !== 1'b0 || rsp_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rsp: got v%b d%0h m%b t%b want all 0", rsp_valid, rsp_data, rsp_mismatch, rsp_timeout); end
    // a stray result while IDLE must be ignored
    valido = 1'b1; data_out = 32'd55;
    repeat (2) @(negedge clk);
    valido = 1'b0;
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin tests_failed++; $display("FAIL idle_valido_ignored: got v%b d%0h want 0/0", rsp_valid, rsp_data); end
  endtask

  task automatic test_basic;
    logic [W-1:0] o0, o1, o2, rd; logic dz, rm, rt; int vr, wc, us, ts, th;
    run_triple(3, 4, 5, 0, 1'b0, '0, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (vr != 3) begin tests_failed++; $display("FAIL basic_validi_run: got %0d want 3", vr); end
    tests_run++; if (o0 !== 3 || o1 !== 4 || o2 !== 5) begin tests_failed++; $display("FAIL basic_operands: got %0d,%0d,%0d want 3,4,5", o0, o1, o2); end
    tests_run++; if (dz !== 1'b1) begin tests_failed++; $display("FAIL basic_data_in_idle: got nonzero want 0"); end
    tests_run++; if (wc != 1) begin tests_failed++; $display("FAIL basic_latency: got %0d want 1", wc); end
    tests_run++; if (rd !== 17 || rm !== 1'b0 || rt !== 1'b0) begin tests_failed++; $display("FAIL basic_rsp: got d%0d m%b t%b want 17/0/0", rd, rm, rt); end
  endtask

  task automatic test_wrap;
    logic [W-1:0] o0, o1, o2, rd; logic dz, rm, rt; int vr, wc, us, ts, th;
    repeat (3) @(negedge clk);
    run_triple(32'hFFFF_FFFF, 2, 3, 0, 1'b1, 32'd1, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (rd !== 1 || rm !== 1'b0 || rt !== 1'b0) begin tests_failed++; $display("FAIL wrap_rsp: got d%0h m%b t%b want 1/0/0", rd, rm, rt); end
  endtask

  task automatic test_mismatch;
    logic [W-1:0] o0, o1, o2, rd; logic dz, rm, rt; int vr, wc, us, ts, th;
    repeat (3) @(negedge clk);
    run_triple(3, 4, 5, 0, 1'b1, 32'd16, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (rd !== 16 || rm !== 1'b1 || rt !== 1'b0) begin tests_failed++; $display("FAIL mismatch_rsp: got d%0d m%b t%b want 16/1/0", rd, rm, rt); end
  endtask

  task automatic test_timeout;
    logic [W-1:0] o0, o1, o2, rd; logic dz, rm, rt; int vr, wc, us, ts, th;
    repeat (3) @(negedge clk);
    run_triple(9, 9, 9, -1, 1'b0, '0, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (rd !== 0 || rm !== 1'b0 || rt !== 1'b1) begin tests_failed++; $display("FAIL timeout_rsp: got d%0d m%b t%b want 0/0/1", rd, rm, rt); end
    tests_run++; if (wc != TO) begin tests_failed++; $display("FAIL timeout_cycles: got %0d want %0d", wc, TO); end
    // now in the GAP cycle: a stray result must leave rsp_* untouched
    valido = 1'b1; data_out = 32'd77;
    @(negedge clk);
    valido = 1'b0;
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_timeout !== 1'b1 || rsp_mismatch !== 1'b0) begin
      tests_failed++; $display("FAIL gap_valido_ignored: got v%b d%0d t%b m%b want 0/0/1/0", rsp_valid, rsp_data, rsp_timeout, rsp_mismatch); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] o0, o1, o2, rd, a, b, c; logic dz, rm, rt; int vr, wc, us, ts, th, ts2, th2;
    repeat (3) @(negedge clk);
    a = $urandom; b = $urandom; c = $urandom;
    run_triple(a, b, c, 0, 1'b0, '0, 5, 1'b1, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (us != 0) begin tests_failed++; $display("FAIL hold_stable: got %0d unstable cycles want 0", us); end
    tests_run++; if (rd !== model_mac(a, b, c) || rm !== 1'b0) begin tests_failed++; $display("FAIL hold_rsp: got %0h m%b want %0h m0", rd, rm, model_mac(a, b, c)); end
    a = $urandom; b = $urandom; c = $urandom;
    run_triple(a, b, c, 0, 1'b0, '0, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts2, th2);
    // GAP cycles follow the handshake cycle, then one IDLE cycle, then SEND_A
    tests_run++; if (ts2 - th != GP + 2) begin tests_failed++; $display("FAIL next_triple_spacing: got %0d want %0d", ts2 - th, GP + 2); end
    tests_run++; if (o0 !== a || o1 !== b || o2 !== c || rd !== model_mac(a, b, c)) begin
      tests_failed++; $display("FAIL second_triple: got %0h,%0h,%0h -> %0h", o0, o1, o2, rd); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] o0, o1, o2, rd; logic dz, rm, rt; int vr, wc, us, ts, th, bad, n;
    repeat (3) @(negedge clk);
    req_a = 1; req_b = 2; req_c = 3; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (validi !== 1'b1 || data_in !== 2) begin tests_failed++; $display("FAIL send_b_state: got %b/%0d want 1/2", validi, data_in); end
    rst = 1'b1;
    #1;
    tests_run++; if (validi !== 1'b0 || data_in !== '0 || rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset: got validi %b data_in %0d rsp_valid %b want 0", validi, data_in, rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      valido = 1'b1; data_out = 32'd6;
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    valido = 1'b0;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL abandoned_no_rsp: got %0d rsp_valid cycles want 0", bad); end
    run_triple(7, 8, 9, 0, 1'b0, '0, 0, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
    tests_run++; if (rd !== 65 || rm !== 1'b0 || rt !== 1'b0) begin tests_failed++; $display("FAIL post_reset_rsp: got d%0d m%b t%b want 65/0/0", rd, rm, rt); end
  endtask

  task automatic test_random;
    logic [W-1:0] o0, o1, o2, rd, a, b, c, good, val, flip, want; logic dz, rm, rt, uv;
    int vr, wc, us, ts, th, lat, hold, k, want_wait; logic want_mis, want_to;
    for (int it = 0; it < 24; it++) begin
      a = $urandom; b = $urandom; c = $urandom;
      if (it % 3 == 0) b = $urandom_range(15, 0);
      good = model_mac(a, b, c);
      lat = $urandom_range(TO + 1, 0);
      uv = ($urandom_range(3, 0) == 0);
      k = $urandom_range(W - 1, 0);
      flip = 1;
      flip = flip << k;
      val = good ^ flip;
      hold = $urandom_range(2, 0);
      if (lat >= TO) begin
        lat = -1; want_to = 1'b1; want_mis = 1'b0; want = '0; want_wait = TO;
      end else begin
        want_to = 1'b0; want_mis = uv; want = uv ? val : good; want_wait = lat + 1;
      end
      exp_q.push_back(want);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_triple(a, b, c, lat, uv, val, hold, 1'b0, o0, o1, o2, vr, dz, wc, rd, rm, rt, us, ts, th);
      want = exp_q.pop_front();
      tests_run++; if (rd !== want || rm !== want_mis || rt !== want_to) begin
        tests_failed++; $display("FAIL rand_rsp[%0d]: got d%0h m%b t%b want d%0h m%b t%b", it, rd, rm, rt, want, want_mis, want_to); end
      tests_run++; if (wc != want_wait) begin tests_failed++; $display("FAIL rand_wait[%0d]: got %0d want %0d", it, wc, want_wait); end
      tests_run++; if (vr != 3 || o0 !== a || o1 !== b || o2 !== c || us != 0) begin
        tests_failed++; $display("FAIL rand_stream[%0d]: got run %0d ops %0h,%0h,%0h unstable %0d", it, vr, o0, o1, o2, us); end
    end
  endtask

  task automatic test_stream_shape;
    tests_run++; if (max_run != 3) begin tests_failed++; $display("FAIL validi_max_run: got %0d want 3", max_run); end
    tests_run++; if (min_low < GP) begin tests_failed++; $display("FAIL validi_min_gap: got %0d want >= %0d", min_low, GP); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_mismatch;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_stream_shape;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
